// File: rtl/unidad_mult_div.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Define MULT_DIV_DIVIDE_EN to build the restoring divider; otherwise DIV/DIVU complete at once with HI/LO unchanged.
module unidad_mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned P_W   = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [P_W-1:0]     p_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, div_zero_q;

    logic               sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     add_sum;
    logic [P_W-1:0]     step_d;
    logic [P_W-1:0]     prod_fix;
    logic [WIDTH-1:0]   hi_d, lo_d;

`ifdef MULT_DIV_DIVIDE_EN
    logic               is_div_q;
    logic               neg_rem_q;
    logic [WIDTH:0]     trial, diff;
    logic [P_W-1:0]     div_step;
    logic [WIDTH-1:0]   quo, rem;
`endif

    // Operand magnitudes and one iteration of shift-add / restoring division
    always_comb begin
        sgn      = ~op[0];
        a_abs    = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
        b_abs    = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
        add_sum  = {1'b0, p_q[P_W-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
        step_d   = {add_sum, p_q[WIDTH-1:1]};
        prod_fix = neg_q ? -p_q : p_q;
        hi_d     = prod_fix[P_W-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
`ifdef MULT_DIV_DIVIDE_EN
        trial    = {p_q[P_W-1:WIDTH], p_q[WIDTH-1]};
        diff     = trial - {1'b0, b_q};
        div_step = diff[WIDTH] ? {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
        quo      = p_q[WIDTH-1:0];
        rem      = p_q[P_W-1:WIDTH];
        if (is_div_q) begin
            step_d = div_step;
            lo_d   = neg_q ? -quo : quo;
            hi_d   = neg_rem_q ? -rem : rem;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            is_div_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        if (op[1]) begin
`ifdef MULT_DIV_DIVIDE_EN
                            if (op_b == '0) begin
                                hi_q       <= op_a;
                                lo_q       <= '1;
                                div_zero_q <= 1'b1;
                                done_q     <= 1'b1;
                                state_q    <= S_DONE;
                            end else begin
                                p_q       <= {{WIDTH{1'b0}}, a_abs};
                                b_q       <= b_abs;
                                neg_q     <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                neg_rem_q <= sgn && op_a[WIDTH-1];
                                is_div_q  <= 1'b1;
                                busy_q    <= 1'b1;
                                state_q   <= S_RUN;
                            end
`else
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            p_q     <= {{WIDTH{1'b0}}, b_abs};
                            b_q     <= a_abs;
                            neg_q   <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
`ifdef MULT_DIV_DIVIDE_EN
                            is_div_q <= 1'b0;
`endif
                        end
                    end else begin
                        if (hi_we) hi_q <= write_data;
                        if (lo_we) lo_q <= write_data;
                    end
                end
                S_RUN: begin
                    p_q   <= step_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
                end
                // Sign correction and result commit
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
